regfile_wr_arbiter: RTL and testbench

Arbitrates the single write port of the 32 x 128-bit wide-word register file (RegFileWW) between two write requesters. Requester A is pipeline writeback; requester B is the load/memory unit. Uses round-robin arbitration with valid/ready handshakes and an optional bounded lock for back-to-back bursts. Outputs are registered and drive RegFileWW's wren/wraddr/wrdata/wrbyteen directly.

---
 rtl/regfile_wr_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Shares the single write port of the 32 x 128-bit wide-word register file
// between two requesters: A (pipeline writeback) and B (load/memory unit).
// Arbitration is round-robin with valid/ready handshakes. A requester can hold
// the grant for a bounded burst of up to MAX_LOCK back-to-back transfers by
// raising its lock input. The register-file write signals are registered, so an
// accepted request appears on them in the following cycle, for one cycle only.
//
// Optional feature: define REGFILE_WR_ARB_INIT_EN to add a clear sweep after
// every reset. The sweep writes zero to every register before either requester
// is served. Without the macro, the arbiter is idle straight after reset and
// init_busy is tied low.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   a_valid/a_ready         requester A handshake (ready is combinational)
//   a_addr/a_data/a_byteen  requester A write address, data and byte enables
//   a_lock                  A asks to keep the grant after this transfer
//   b_*                     the same set for requester B
//   wren/wraddr/wrdata/wrbyteen  registered write port to the register file
//   owner                   00 none, 01 A holds a lock, 10 B holds a lock
//   init_busy               clear sweep in progress
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
   parameter int DATA_W   = 128,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32,
   parameter int MAX_LOCK = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic [ADDR_W-1:0]   a_addr,
   input  logic [DATA_W-1:0]   a_data,
   input  logic [DATA_W/8-1:0] a_byteen,
   input  logic                a_lock,
   input  logic                b_valid,
   output logic                b_ready,
   input  logic [ADDR_W-1:0]   b_addr,
   input  logic [DATA_W-1:0]   b_data,
   input  logic [DATA_W/8-1:0] b_byteen,
   input  logic                b_lock,
   output logic                wren,
   output logic [ADDR_W-1:0]   wraddr,
   output logic [DATA_W-1:0]   wrdata,
   output logic [DATA_W/8-1:0] wrbyteen,
   output logic [1:0]          owner,
   output logic                init_busy
);

   localparam int BE_W = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   // The lock counter reaches this value on the last grant of a burst.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);
   // With MAX_LOCK of 1, a lock can never extend past the first grant.
   localparam bit LOCK_EN = (MAX_LOCK > 1);

   // Elaboration-time sanity check of the configuration.
   if ((MAX_LOCK < 1) || (NUM_REGS < 1) || (NUM_REGS > (2 ** ADDR_W)) || ((DATA_W % 8) != 0)) begin : g_bad_cfg
      $error("regfile_wr_arbiter: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_OWN_A = 2'b01,
      ST_OWN_B = 2'b10,
      ST_INIT  = 2'b11
   } state_e;

`ifdef REGFILE_WR_ARB_INIT_EN
   localparam state_e RESET_STATE = ST_INIT;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
`else
   localparam state_e RESET_STATE = ST_IDLE;
`endif

   // The owner code exposed outside; the sweep and idle both report "none".
   function automatic logic [1:0] owner_code(input state_e st);
      logic [1:0] code;
      case (st)
         ST_OWN_A: code = 2'b01;
         ST_OWN_B: code = 2'b10;
         default:  code = 2'b00;
      endcase
      return code;
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Round-robin pointer: 1 when B won the last grant, so A wins the next tie.
   logic             ptr_b_q, ptr_b_d;
   logic             a_gnt_s, b_gnt_s;

   logic              wren_q;
   logic [ADDR_W-1:0] wraddr_q;
   logic [DATA_W-1:0] wrdata_q;
   logic [BE_W-1:0]   wrbyteen_q;
   logic [1:0]        owner_q;

`ifdef REGFILE_WR_ARB_INIT_EN
   logic [ADDR_W-1:0] init_addr_q;
   logic              init_busy_q;
`endif

   // Grant selection and next-state for the arbitration FSM.
   always_comb begin
      a_gnt_s = 1'b0;
      b_gnt_s = 1'b0;
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_b_d = ptr_b_q;
      case (state_q)
         ST_IDLE: begin
            if (a_valid && (!b_valid || ptr_b_q)) begin
               a_gnt_s = 1'b1;
               ptr_b_d = 1'b0;
               if (a_lock && LOCK_EN) begin
                  state_d = ST_OWN_A;
                  cnt_d   = CNT_W'(1);
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (b_valid) begin
               b_gnt_s = 1'b1;
               ptr_b_d = 1'b1;
               if (b_lock && LOCK_EN) begin
                  state_d = ST_OWN_B;
                  cnt_d   = CNT_W'(1);
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OWN_A: begin
            // A dropping valid ends the burst without a grant this cycle.
            if (a_valid) begin
               a_gnt_s = 1'b1;
               ptr_b_d = 1'b0;
               if (a_lock && (cnt_q < CNT_LAST)) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = {CNT_W{1'b0}};
               end
            end else begin
               state_d = ST_IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end
         end
         ST_OWN_B: begin
            if (b_valid) begin
               b_gnt_s = 1'b1;
               ptr_b_d = 1'b1;
               if (b_lock && (cnt_q < CNT_LAST)) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = {CNT_W{1'b0}};
               end
            end else begin
               state_d = ST_IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end
         end
`ifdef REGFILE_WR_ARB_INIT_EN
         ST_INIT: begin
            if (init_addr_q == LAST_ADDR) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_INIT;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Readies are forced low while reset is held, even though the FSM is idle.
   assign a_ready = a_gnt_s & rst_n;
   assign b_ready = b_gnt_s & rst_n;

   // FSM state, round-robin pointer, lock count and registered write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RESET_STATE;
         cnt_q       <= {CNT_W{1'b0}};
         ptr_b_q     <= 1'b1;
         owner_q     <= 2'b00;
         wren_q      <= 1'b0;
         wraddr_q    <= {ADDR_W{1'b0}};
         wrdata_q    <= {DATA_W{1'b0}};
         wrbyteen_q  <= {BE_W{1'b0}};
`ifdef REGFILE_WR_ARB_INIT_EN
         init_addr_q <= {ADDR_W{1'b0}};
         init_busy_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_b_q <= ptr_b_d;
         owner_q <= owner_code(state_d);
`ifdef REGFILE_WR_ARB_INIT_EN
         init_busy_q <= (state_d == ST_INIT);
         if (state_q == ST_INIT) begin
            wren_q      <= 1'b1;
            wraddr_q    <= init_addr_q;
            wrdata_q    <= {DATA_W{1'b0}};
            wrbyteen_q  <= {BE_W{1'b1}};
            init_addr_q <= init_addr_q + ADDR_W'(1);
         end else
`endif
         // A zero byte-enable transfer is accepted but never reaches the file;
         // the address/data/byteen outputs keep their previous values.
         if (a_gnt_s && (a_byteen != {BE_W{1'b0}})) begin
            wren_q     <= 1'b1;
            wraddr_q   <= a_addr;
            wrdata_q   <= a_data;
            wrbyteen_q <= a_byteen;
         end else if (b_gnt_s && (b_byteen != {BE_W{1'b0}})) begin
            wren_q     <= 1'b1;
            wraddr_q   <= b_addr;
            wrdata_q   <= b_data;
            wrbyteen_q <= b_byteen;
         end else begin
            wren_q <= 1'b0;
         end
      end
   end

   assign wren     = wren_q;
   assign wraddr   = wraddr_q;
   assign wrdata   = wrdata_q;
   assign wrbyteen = wrbyteen_q;
   assign owner    = owner_q;
`ifdef REGFILE_WR_ARB_INIT_EN
   assign init_busy = init_busy_q;
`else
   assign init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// The stimulus process drives requests at the falling edge. A behavioural model
// decides which requester wins and checks the ready lines. The model then
// queues the write-port response expected after the next rising edge. A
// separate monitor pops one entry per rising edge and compares it with the
// DUT's write port. The monitor also plays the role of the register file, so
// stored values can be compared with the model's copy.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

   localparam int DATA_W   = 128;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   localparam int MAX_LOCK = 4;
   localparam int BE_W     = DATA_W / 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              a_valid = 1'b0, a_ready, a_lock = 1'b0;
   logic [ADDR_W-1:0] a_addr = '0;
   logic [DATA_W-1:0] a_data = '0;
   logic [BE_W-1:0]   a_byteen = '0;
   logic              b_valid = 1'b0, b_ready, b_lock = 1'b0;
   logic [ADDR_W-1:0] b_addr = '0;
   logic [DATA_W-1:0] b_data = '0;
   logic [BE_W-1:0]   b_byteen = '0;
   logic              wren;
   logic [ADDR_W-1:0] wraddr;
   logic [DATA_W-1:0] wrdata;
   logic [BE_W-1:0]   wrbyteen;
   logic [1:0]        owner;
   logic              init_busy;

   always #5 clk = ~clk;

   regfile_wr_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .MAX_LOCK(MAX_LOCK)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .a_byteen(a_byteen), .a_lock(a_lock),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .b_byteen(b_byteen), .b_lock(b_lock),
      .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .wrbyteen(wrbyteen),
      .owner(owner), .init_busy(init_busy)
   );

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [BE_W-1:0]   be;
      logic [1:0]        own;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   logic [DATA_W-1:0] rf_dut   [NUM_REGS];
   logic [DATA_W-1:0] rf_model [NUM_REGS];

   // Model state: last winner, current burst holder (0 none, 1 A, 2 B),
   // grants so far in that burst, and the clear sweep position.
   bit m_last_b;
   int m_own;
   int m_burst;
   bit m_init;
   int m_init_addr;

   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic [BE_W-1:0] be);
      logic [DATA_W-1:0] r;
      r = old_v;
      for (int i = 0; i < BE_W; i++) begin
         if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: one expected entry per rising edge while stimulus is running.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wren", {127'd0, wren}, {127'd0, e.wr});
            check("owner", {126'd0, owner}, {126'd0, e.own});
            if (e.wr) begin
               check("wraddr", {123'd0, wraddr}, {123'd0, e.addr});
               check("wrdata", wrdata, e.data);
               check("wrbyteen", {112'd0, wrbyteen}, {112'd0, e.be});
            end
         end else if (wren === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: wren=1 addr=%0d with nothing expected (t=%0t)", wraddr, $time);
         end
         if (wren === 1'b1) rf_dut[wraddr] = merge(rf_dut[wraddr], wrdata, wrbyteen);
      end
   end

   // One cycle of stimulus: apply inputs, run the model, check readies, queue the response.
   task automatic drive(input bit av, input logic [ADDR_W-1:0] aad, input logic [DATA_W-1:0] ad,
                        input logic [BE_W-1:0] abe, input bit al,
                        input bit bv, input logic [ADDR_W-1:0] bad, input logic [DATA_W-1:0] bd,
                        input logic [BE_W-1:0] bbe, input bit bl,
                        output bit ga, output bit gb);
      exp_t e;
      bit   lk;
      @(negedge clk);
      a_valid = av; a_addr = aad; a_data = ad; a_byteen = abe; a_lock = al;
      b_valid = bv; b_addr = bad; b_data = bd; b_byteen = bbe; b_lock = bl;
      #1;
      check("init_busy", {127'd0, init_busy}, {127'd0, m_init});
      ga = 1'b0;
      gb = 1'b0;
      e  = '0;
      if (m_init) begin
         e.wr = 1'b1;
         e.addr = m_init_addr[ADDR_W-1:0];
         e.data = '0;
         e.be = '1;
         rf_model[m_init_addr] = '0;
         if (m_init_addr == NUM_REGS - 1) m_init = 1'b0;
         m_init_addr++;
      end else begin
         if (m_own == 0) begin
            if (av && bv) begin
               ga = m_last_b;
               gb = !m_last_b;
            end else begin
               ga = av;
               gb = bv;
            end
         end else if (m_own == 1) begin
            ga = av;
         end else begin
            gb = bv;
         end
         if (m_own != 0 && !ga && !gb) begin
            m_own = 0;
            m_burst = 0;
         end else if (ga || gb) begin
            m_last_b = gb;
            lk = ga ? al : bl;
            if (m_own == 0) begin
               if (lk && MAX_LOCK > 1) begin
                  m_own = ga ? 1 : 2;
                  m_burst = 1;
               end
            end else begin
               m_burst++;
               if (!lk || m_burst >= MAX_LOCK) begin
                  m_own = 0;
                  m_burst = 0;
               end
            end
            if ((ga ? abe : bbe) != '0) begin
               e.wr = 1'b1;
               e.addr = ga ? aad : bad;
               e.data = ga ? ad : bd;
               e.be = ga ? abe : bbe;
               rf_model[e.addr] = merge(rf_model[e.addr], e.data, e.be);
            end
         end
      end
      e.own = m_own[1:0];
      check("a_ready", {127'd0, a_ready}, {127'd0, ga});
      check("b_ready", {127'd0, b_ready}, {127'd0, gb});
      exp_q.push_back(e);
   endtask

   function automatic logic [DATA_W-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle();
      bit ga, gb;
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, ga, gb);
   endtask

   // Reset with both requesters pushing; optionally run through the clear sweep.
   task automatic do_reset(input bit drain);
      bit ga, gb;
      @(negedge clk);
      rst_n = 1'b0;
      a_valid = 1'b1;
      b_valid = 1'b1;
      #1;
      check("rst_a_ready", {127'd0, a_ready}, 128'd0);
      check("rst_b_ready", {127'd0, b_ready}, 128'd0);
      check("rst_wren", {127'd0, wren}, 128'd0);
      check("rst_owner", {126'd0, owner}, 128'd0);
      check("rst_wrdata", wrdata, 128'd0);
      check("rst_wraddr", {123'd0, wraddr}, 128'd0);
      check("rst_wrbyteen", {112'd0, wrbyteen}, 128'd0);
      repeat (2) @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      exp_q.delete();
      m_last_b = 1'b1;
      m_own = 0;
      m_burst = 0;
`ifdef REGFILE_WR_ARB_INIT_EN
      m_init = 1'b1;
`else
      m_init = 1'b0;
`endif
      m_init_addr = 0;
      while (drain && m_init) begin
         drive(1'b1, 5'($urandom), rnd128(), '1, 1'b0, 1'b1, 5'($urandom), rnd128(), '1, 1'b0, ga, gb);
      end
   endtask

   initial begin
      bit ga, gb, pa, pb;
      logic [ADDR_W-1:0] aa, ba;
      logic [DATA_W-1:0] ad, bd, v1, v7;
      logic [BE_W-1:0]   abe, bbe;

      for (int i = 0; i < NUM_REGS; i++) begin
         rf_dut[i] = '0;
         rf_model[i] = '0;
      end
      do_reset(1'b1);

      // A alone writes register 3.
      v1 = 128'h0123_4567_89ab_cdef_0f1e_2d3c_eac2_2354;
      drive(1'b1, 5'd3, v1, 16'hffff, 1'b0, 1'b0, '0, '0, '0, 1'b0, ga, gb);
      idle();
      idle();
      check("reg3_value", rf_dut[3], v1);

      // Both valid, no lock: alternation starting with A.
      do_reset(1'b1);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 5'($urandom), rnd128(), '1, 1'b0, 1'b1, 5'($urandom), rnd128(), '1, 1'b0, ga, gb);
         check("alt_grant_a", {127'd0, ga}, {127'd0, (i % 2 == 0)});
      end

      // A locks while B waits: four A grants, then B.
      do_reset(1'b1);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 5'd1, rnd128(), '1, 1'b1, 1'b1, 5'd2, rnd128(), '1, 1'b0, ga, gb);
         check("lock_grant_b", {127'd0, gb}, {127'd0, (i == 4)});
      end

      // A locks, then drops valid for one cycle: B next.
      do_reset(1'b1);
      drive(1'b1, 5'd4, rnd128(), '1, 1'b1, 1'b1, 5'd5, rnd128(), '1, 1'b0, ga, gb);
      drive(1'b0, 5'd4, rnd128(), '1, 1'b1, 1'b1, 5'd5, rnd128(), '1, 1'b0, ga, gb);
      drive(1'b0, 5'd4, rnd128(), '1, 1'b0, 1'b1, 5'd5, rnd128(), '1, 1'b0, ga, gb);
      check("drop_then_b", {127'd0, gb}, 128'd1);

      // Zero byte enables: accepted but register 7 keeps its value.
      v7 = rnd128();
      drive(1'b1, 5'd7, v7, '1, 1'b0, 1'b0, '0, '0, '0, 1'b0, ga, gb);
      drive(1'b1, 5'd7, ~v7, 16'h0000, 1'b0, 1'b0, '0, '0, '0, 1'b0, ga, gb);
      check("be0_accepted", {127'd0, ga}, 128'd1);
      idle();
      idle();
      check("reg7_unchanged", rf_dut[7], v7);

`ifdef REGFILE_WR_ARB_INIT_EN
      // Reset in the middle of the sweep restarts it at address 0.
      do_reset(1'b0);
      repeat (10) drive(1'b1, '0, rnd128(), '1, 1'b0, 1'b1, '0, rnd128(), '1, 1'b0, ga, gb);
      do_reset(1'b1);
      for (int i = 0; i < NUM_REGS; i++) check("swept_zero", rf_dut[i], 128'd0);
`endif

      // Randomised traffic; a request holds its payload until accepted.
      pa = 1'b0;
      pb = 1'b0;
      aa = '0; ba = '0; ad = '0; bd = '0; abe = '0; bbe = '0;
      for (int n = 0; n < 400; n++) begin
         if (n == 200) begin
            do_reset(1'b1);
            pa = 1'b0;
            pb = 1'b0;
         end
         if (!pa && $urandom_range(0, 9) < 7) begin
            pa = 1'b1; aa = 5'($urandom); ad = rnd128();
            abe = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         end
         if (!pb && $urandom_range(0, 9) < 7) begin
            pb = 1'b1; ba = 5'($urandom); bd = rnd128();
            bbe = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         end
         drive(pa, aa, ad, abe, ($urandom_range(0, 9) < 4), pb, ba, bd, bbe, ($urandom_range(0, 9) < 4), ga, gb);
         if (ga) pa = 1'b0;
         if (gb) pb = 1'b0;
      end
      idle();
      idle();
      for (int i = 0; i < NUM_REGS; i++) check("rf_contents", rf_dut[i], rf_model[i]);
      @(posedge clk);
      #2;
      check("queue_drained", 128'(exp_q.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
